// File: rtl/ex_muldiv_stage.sv
// ----------------------------------------------------------------------------
// ex_muldiv_stage
//
// EX-stage RV32M multiply/divide unit sitting directly behind the forwarding
// unit. It builds its operands from the ForwardA/ForwardB selects and latches
// them together with funct3 on the start cycle. It then iterates one bit per
// cycle: shift-add for multiply, restoring division for divide. While it is
// busy it requests a pipeline stall, and it presents the result for the
// EX/MEM register in DONE.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   Defined   : multiply ops use a single-cycle combinational multiplier and
//               go from IDLE straight to DONE.
//   Undefined : multiply ops are iterative and take XLEN cycles.
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   ex_valid       EX holds a valid instruction
//   ex_is_muldiv   EX instruction is an RV32M op
//   ex_funct3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   ex_rs1_data    rs1 from the ID/EX register
//   ex_rs2_data    rs2 from the ID/EX register
//   mem_fwd_data   forwarded value from the MEM stage
//   wb_fwd_data    forwarded value from the WB stage
//   ForwardA/B     operand selects: 10 MEM, 01 WB, 00/11 register file
//   flush          kill the EX instruction
//   pipe_hold      external stall keeping EX occupied (holds DONE)
//   stall_req      busy; freeze IF/ID/EX and send a bubble into MEM
//   result         computed value (zero outside DONE)
//   result_valid   result is valid this cycle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a muldiv instruction in EX
// CALC  | iterating one bit per cycle, counter counts XLEN-1 down to 0
// DONE  | result presented; held while pipe_hold is high
// ----------------------------------------------------------------------------
module ex_muldiv_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_is_muldiv,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1_data,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [XLEN-1:0] wb_fwd_data,
   input  logic [1:0]      ForwardA,
   input  logic [1:0]      ForwardB,
   input  logic            flush,
   input  logic            pipe_hold,
   output logic            stall_req,
   output logic [XLEN-1:0] result,
   output logic            result_valid
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic [XLEN-1:0]   opa, opb;
   logic              start;
   logic              is_div, sgn_a, sgn_b, a_neg, b_neg, neg_start;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh;
   logic [XLEN-1:0]   rem_diff;
   logic              rem_ge;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   div_pick;
   logic [XLEN-1:0]   div_res;

   // Operand mux from the forwarding unit
   always_comb begin
      case (ForwardA)
         2'b10:   opa = mem_fwd_data;
         2'b01:   opa = wb_fwd_data;
         default: opa = ex_rs1_data;
      endcase
      case (ForwardB)
         2'b10:   opb = mem_fwd_data;
         2'b01:   opb = wb_fwd_data;
         default: opb = ex_rs2_data;
      endcase
   end

   // Reset gates start so that stall_req drops the moment rst_n goes low,
   // even while EX still holds the muldiv instruction.
   assign start = rst_n & ex_valid & ex_is_muldiv & ~flush & (state_q == IDLE);

   // Signedness of each operand for the incoming op. MUL is treated as
   // unsigned: its low half does not depend on operand signs.
   assign is_div = ex_funct3[2];
   assign sgn_a  = (ex_funct3 == 3'b001) | (ex_funct3 == 3'b010) |
                   (ex_funct3 == 3'b100) | (ex_funct3 == 3'b110);
   assign sgn_b  = (ex_funct3 == 3'b001) | (ex_funct3 == 3'b100) |
                   (ex_funct3 == 3'b110);
   assign a_neg  = sgn_a & opa[XLEN-1];
   assign b_neg  = sgn_b & opb[XLEN-1];
   assign mag_a  = a_neg ? (~opa + 1'b1) : opa;
   assign mag_b  = b_neg ? (~opb + 1'b1) : opb;

   // REM takes the dividend's sign; all other ops negate on a sign mismatch
   assign neg_start = (is_div & ex_funct3[1]) ? a_neg : (a_neg ^ b_neg);

   assign div_zero = is_div & (opb == '0);
   assign div_ovf  = ((ex_funct3 == 3'b100) | (ex_funct3 == 3'b110)) &
                     (opa == MIN_NEG) & (opb == '1);
   assign special  = div_zero | div_ovf;
   always_comb begin
      if (ex_funct3[1]) special_res = div_zero ? opa : '0;
      else              special_res = div_zero ? '1  : MIN_NEG;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [2*XLEN-1:0] fast_fix;
   logic [XLEN-1:0]   fast_res;
   always_comb begin
      fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
      fast_fix  = neg_start ? (~fast_prod + 1'b1) : fast_prod;
      fast_res  = (ex_funct3[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
   end
`endif

   // Multiply step: acc = {partial high, remaining multiplier}, add the
   // multiplicand when the multiplier LSB is set, then shift right.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
   end

   // Restoring divide step: acc = {remainder, dividend/quotient}. The shifted
   // remainder needs XLEN+1 bits; after a successful subtract it is below the
   // divisor again, so the XLEN-bit difference is exact.
   always_comb begin
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      rem_ge   = (rem_sh >= {1'b0, opb_q});
      rem_diff = rem_sh[XLEN-1:0] - opb_q;
      div_next = rem_ge ? {rem_diff,          acc_q[XLEN-2:0], 1'b1}
                        : {rem_sh[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      step     = op_q[2] ? div_next : mul_next;
      prod_fix = neg_q ? (~step + 1'b1) : step;
      mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      div_pick = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
      div_res  = neg_q ? (~div_pick + 1'b1) : div_pick;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      op_d    = op_q;
      neg_d   = neg_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = ex_funct3;
               neg_d = neg_start;
               cnt_d = CW'(XLEN-1);
               if (special) begin
                  res_d   = special_res;
                  state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
               end else if (!is_div) begin
                  res_d   = fast_res;
                  state_d = DONE;
`endif
               end else if (is_div) begin
                  acc_d   = {{XLEN{1'b0}}, mag_a};
                  opb_d   = mag_b;
                  state_d = CALC;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, mag_b};
                  opb_d   = mag_a;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step;
            if (cnt_q == '0) begin
               res_d   = op_q[2] ? div_res : mul_res;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (!pipe_hold) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign stall_req    = start | ((state_q == CALC) & ~flush);
   assign result_valid = (state_q == DONE);
   assign result       = result_valid ? res_q : '0;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
module tb_ex_muldiv_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_is_muldiv;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1_data, ex_rs2_data, mem_fwd_data, wb_fwd_data;
   logic [1:0]  ForwardA, ForwardB;
   logic        flush, pipe_hold;
   logic        stall_req;
   logic [31:0] result;
   logic        result_valid;

   int errors = 0;
   int checks = 0;

   ex_muldiv_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv), .ex_funct3(ex_funct3),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .flush(flush), .pipe_hold(pipe_hold),
      .stall_req(stall_req), .result(result), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics in plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic [63:0] up;
      int ia, ib;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'b0, b};
      ia  = a;
      ib  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if (((f3 == 3'd4) || (f3 == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return 33;
   endfunction

   task automatic scramble();
      ex_rs1_data  = $urandom;
      ex_rs2_data  = $urandom;
      mem_fwd_data = 32'd99;
      wb_fwd_data  = $urandom;
      ForwardA     = 2'($urandom_range(0, 3));
      ForwardB     = 2'($urandom_range(0, 3));
      ex_funct3    = 3'($urandom_range(0, 7));
   endtask

   // Called in an IDLE cycle just after the edge; returns in the IDLE cycle
   // following DONE, so consecutive calls are back-to-back operations.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                         input int hold, input bit chg);
      logic [31:0] exp, held;
      int lat, k;
      bit done;
      exp = model(f3, a, b);
      lat = latency(f3, a, b);
      ex_rs1_data  = $urandom;
      ex_rs2_data  = $urandom;
      mem_fwd_data = $urandom;
      wb_fwd_data  = $urandom;
      ForwardA = fa;
      ForwardB = fb;
      case (fa)
         2'b10:   mem_fwd_data = a;
         2'b01:   wb_fwd_data  = a;
         default: ex_rs1_data  = a;
      endcase
      case (fb)
         2'b10:   mem_fwd_data = b;
         2'b01:   wb_fwd_data  = b;
         default: ex_rs2_data  = b;
      endcase
      ex_funct3    = f3;
      ex_valid     = 1'b1;
      ex_is_muldiv = 1'b1;
      #1;
      check({tag, " start_stall"}, 32'(stall_req), 32'd1);
      check({tag, " idle_valid"}, 32'(result_valid), 32'd0);
      k = 0;
      done = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1 && chg) scramble();
         #1;
         if (result_valid) begin
            done = 1;
            check({tag, " latency"}, 32'(k), 32'(lat));
            check({tag, " result"}, result, exp);
            check({tag, " done_stall"}, 32'(stall_req), 32'd0);
         end else if (stall_req !== 1'b1) begin
            check({tag, " busy_stall"}, 32'(stall_req), 32'd1);
         end
      end
      if (!done) check({tag, " timeout"}, 32'(k), 32'(lat));
      held = result;
      ex_valid  = 1'b0;
      pipe_hold = (hold > 0);
      for (int h = 1; h <= hold; h++) begin
         @(posedge clk);
         #2;
         check({tag, " hold_valid"}, 32'(result_valid), 32'd1);
         check({tag, " hold_result"}, result, held);
         check({tag, " hold_stall"}, 32'(stall_req), 32'd0);
         pipe_hold = (h < hold);
      end
      @(posedge clk);
      #1;
      check({tag, " back_idle"}, 32'(result_valid), 32'd0);
   endtask

   initial begin
      logic [1:0]  fa, fb;
      logic [31:0] a, b;
      rst_n = 1'b0;
      ex_valid = 0; ex_is_muldiv = 0; ex_funct3 = 0;
      ex_rs1_data = 0; ex_rs2_data = 0; mem_fwd_data = 0; wb_fwd_data = 0;
      ForwardA = 0; ForwardB = 0; flush = 0; pipe_hold = 0;
      #12;
      check("reset valid", 32'(result_valid), 32'd0);
      check("reset result", result, 32'd0);
      check("reset stall", 32'(stall_req), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul_fwd", 3'd0, 32'd6, 32'd7, 2'b10, 2'b00, 0, 1);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b01, 0, 0);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b01, 0, 0);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 2'b11, 2'b00, 0, 1);
      run_op("div_z", 3'd4, 32'd7, 32'd0, 2'b00, 2'b00, 0, 0);
      run_op("remu_z", 3'd7, 32'd7, 32'd0, 2'b00, 2'b00, 0, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0);
      run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 0, 0);
      run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 0, 1);
      run_op("divu", 3'd5, 32'd100, 32'd7, 2'b00, 2'b00, 0, 0);
      run_op("hold3", 3'd5, 32'd100, 32'd7, 2'b00, 2'b00, 3, 0);

      // Flush ten cycles into a DIV
      ex_rs1_data = 32'd1000; ex_rs2_data = 32'd3; ForwardA = 0; ForwardB = 0;
      ex_funct3 = 3'd4; ex_valid = 1; ex_is_muldiv = 1;
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check("flush stall", 32'(stall_req), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      check("flush idle_start", 32'(stall_req), 32'd1);
      check("flush valid", 32'(result_valid), 32'd0);
      ex_valid = 1'b0;
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid !== 1'b0 || stall_req !== 1'b0) pulses++;
         end
         check("flush no_pulse", 32'(pulses), 32'd0);
      end

      // Reset in the middle of CALC with EX still holding the instruction
      ex_rs1_data = 32'd12345; ex_rs2_data = 32'd678; ex_funct3 = 3'd0;
      ex_valid = 1; ex_is_muldiv = 1;
      for (int i = 0; i < 6; i++) @(posedge clk);
      #1;
      check("pre_rst stall", 32'(stall_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst stall", 32'(stall_req), 32'd0);
      check("rst valid", 32'(result_valid), 32'd0);
      check("rst result", result, 32'd0);
      ex_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random operations against the reference model
      for (int n = 0; n < 30; n++) begin
         fa = 2'($urandom_range(0, 3));
         fb = 2'($urandom_range(0, 3));
         if ((fa == fb) && (fa == 2'b10 || fa == 2'b01)) fb = 2'b00;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'($urandom_range(0, 255));
            3: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op("rand", 3'($urandom_range(0, 7)), a, b, fa, fb, int'($urandom_range(0, 2)), n[0]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
